// File: rtl/flappybird_mem_pkg.sv
// Shared definitions for the FlappyBird on-chip RAM arbiter.
// Holds the default widths, the controller state encoding and the
// port identifiers used by the arbiter and the read pipeline tag.
package flappybird_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 2;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_BE_W   = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/flappybird_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset   - clock, async active-high reset
//   en           - grants allowed this cycle (RUN and not held)
//   req0, req1   - port requests
//   gnt0, gnt1   - one-hot grant, combinational
// The last-grant flop only advances when a grant actually issues, so a
// held or clearing controller keeps its fairness history.
module flappybird_rr_arb2
  import flappybird_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_q, last_d;
  logic pick;

  always_comb begin
    // On a tie the port that did not win last time goes next.
    pick   = (req0 && req1) ? ~last_q : req1;
    gnt0   = en && req0 && (pick == P0);
    gnt1   = en && req1 && (pick == P1);
    last_d = last_q;
    if (gnt0 || gnt1) last_d = pick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= P1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/flappybird_soc_onchip_mem_arbiter.sv
// Two-master front end for the single-port on-chip RAM.
// Zero-fills the RAM after reset, then shares it round-robin between
// port 0 (Nios data master) and port 1 (game-logic engine).
// Ports:
//   clk, reset, hold           - clock, async reset, freeze request
//   mN_*                       - Avalon-MM slave side for master N
//   mem_*                      - single-port RAM side (mem_readdata is q,
//                                valid the cycle after the address edge)
//   busy                       - clearing or a read is in flight
module flappybird_soc_onchip_mem_arbiter
  import flappybird_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned BE_W           = DEF_BE_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              mem_clken,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_own_q, rd_own_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rdv0_q, rdv0_d;
  logic              rdv1_q, rdv1_d;

  logic req0, req1, gnt0, gnt1, arb_en;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign arb_en = (state_q == RUN) && !hold;

  flappybird_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    state_d        = state_q;
    clear_cnt_d    = clear_cnt_q;
    rd_vld_d       = rd_vld_q;
    rd_own_d       = rd_own_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    rdv0_d         = rdv0_q;
    rdv1_d         = rdv1_q;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;

    if (state_q == CLEAR) begin
      mem_address    = clear_cnt_q;
      mem_byteenable = '1;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      if (!hold) begin
        if (clear_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = RUN;
          clear_cnt_d = '0;
        end else begin
          clear_cnt_d = clear_cnt_q + ADDR_W'(1);
        end
      end
    end else if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
    end

    // Stage 1 tags the accepted read; stage 2 captures RAM q for the owner.
    // Everything freezes with hold because the RAM q freezes too.
    if (!hold) begin
      rd_vld_d = (gnt0 && m0_read) || (gnt1 && m1_read);
      rd_own_d = gnt1 ? P1 : P0;
      rdv0_d   = rd_vld_q && (rd_own_q == P0);
      rdv1_d   = rd_vld_q && (rd_own_q == P1);
      if (rd_vld_q && (rd_own_q == P0)) rdata0_d = mem_readdata;
      if (rd_vld_q && (rd_own_q == P1)) rdata1_d = mem_readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clear_cnt_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_own_q    <= P0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rdv0_q      <= 1'b0;
      rdv1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_own_q    <= rd_own_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      rdv0_q      <= rdv0_d;
      rdv1_q      <= rdv1_d;
    end
  end

  assign m0_waitrequest   = req0 & ~gnt0;
  assign m1_waitrequest   = req1 & ~gnt1;
  assign m0_readdata      = rdata0_q;
  assign m1_readdata      = rdata1_q;
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign mem_clken        = ~hold;
  assign busy             = (state_q == CLEAR) | rd_vld_q;

endmodule

// File: tb/tb_flappybird_soc_onchip_mem_arbiter.sv
module tb_flappybird_soc_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_clken, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  flappybird_soc_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken), .busy(busy)
  );

  // RAM model: garbage preload, byte-lane writes, registered q, clken gating.
  logic [31:0] ram [4];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4; i++) ram[i] <= 32'hA5A5_0000 | i;
      ram_init <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = 0; m1_address = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = 0; m1_writedata = 0;
  endtask

  task automatic test_reset();
    reset = 1; hold = 0; idle();
    m0_read = 1; m1_write = 1; m1_address = 2'd1; m1_writedata = 32'h5555_5555;
    step(); step();
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv0 got=%b exp=0", m0_readdatavalid); end
    total++; if (m0_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata0 got=%h exp=0", m0_readdata); end
    total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait0 got=%b exp=1", m0_waitrequest); end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (mem_address !== 2'(i)) begin bad++; $display("FAIL clr_addr[%0d] got=%0d exp=%0d", i, mem_address, i); end
      total++; if ({mem_chipselect, mem_write, mem_byteenable} !== 6'b11_1111) begin bad++; $display("FAIL clr_ctl[%0d] got=%b exp=111111", i, {mem_chipselect, mem_write, mem_byteenable}); end
      total++; if (mem_writedata !== 32'h0) begin bad++; $display("FAIL clr_wd[%0d] got=%h exp=0", i, mem_writedata); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy[%0d] got=%b exp=1", i, busy); end
      total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin bad++; $display("FAIL clr_wait[%0d] got=%b exp=11", i, {m0_waitrequest, m1_waitrequest}); end
      step();
    end
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin bad++; $display("FAIL first_grant got=%b exp=01", {m0_waitrequest, m1_waitrequest}); end
    total++; if ({mem_chipselect, mem_write, mem_address} !== 4'b1000) begin bad++; $display("FAIL first_mux got=%b exp=1000", {mem_chipselect, mem_write, mem_address}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_busy got=%b exp=0", busy); end
    step(); idle(); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL inflight_busy got=%b exp=1", busy); end
    step(); #1;
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin bad++; $display("FAIL clr_read0 got=%b/%h exp=1/00000000", m0_readdatavalid, m0_readdata); end
    step();
  endtask

  task automatic test_write_read();
    m0_write = 1; m0_address = 2'd2; m0_byteenable = 4'b0011; m0_writedata = 32'hDEAD_BEEF; #1;
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_wait got=%b exp=0", m0_waitrequest); end
    total++; if ({mem_write, mem_address, mem_byteenable} !== 7'b1_10_0011) begin bad++; $display("FAIL wr_mux got=%b exp=1100011", {mem_write, mem_address, mem_byteenable}); end
    step();
    m0_write = 0; m0_read = 1; #1;
    total++; if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b010) begin bad++; $display("FAIL rd_issue got=%b exp=010", {m0_waitrequest, mem_chipselect, mem_write}); end
    step(); idle(); #1;
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_early got=%b exp=0", m0_readdatavalid); end
    step(); #1;
    total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", m0_readdatavalid); end
    total++; if (m0_readdata !== 32'h0000_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=0000beef", m0_readdata); end
    step(); #1;
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_pulse got=%b exp=0", m0_readdatavalid); end
  endtask

  task automatic test_back_to_back();
    logic exp_g0;
    m0_write = 1; m0_address = 2'd0; m0_writedata = 32'h1111_1111; step();
    idle(); m1_write = 1; m1_address = 2'd3; m1_writedata = 32'h3333_3333; step();
    idle();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin m0_read = 1; m0_address = 2'd0; m1_read = 1; m1_address = 2'd3; end
      else idle();
      #1;
      exp_g0 = (k % 2 == 0);
      if (k < 8) begin
        total++; if ({m0_waitrequest, m1_waitrequest} !== {~exp_g0, exp_g0}) begin bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", k, {m0_waitrequest, m1_waitrequest}, {~exp_g0, exp_g0}); end
      end
      if (k >= 2) begin
        total++; if ({m0_readdatavalid, m1_readdatavalid} !== {exp_g0, ~exp_g0}) begin bad++; $display("FAIL b2b_rdv[%0d] got=%b exp=%b", k, {m0_readdatavalid, m1_readdatavalid}, {exp_g0, ~exp_g0}); end
        if (exp_g0) begin
          total++; if (m0_readdata !== 32'h1111_1111) begin bad++; $display("FAIL b2b_d0[%0d] got=%h exp=11111111", k, m0_readdata); end
        end else begin
          total++; if (m1_readdata !== 32'h3333_3333) begin bad++; $display("FAIL b2b_d1[%0d] got=%h exp=33333333", k, m1_readdata); end
        end
      end
      step();
    end
  endtask

  task automatic test_hold();
    idle(); m0_read = 1; m0_address = 2'd0; #1;
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL hold_issue got=%b exp=0", m0_waitrequest); end
    step(); idle(); step();
    hold = 1; m1_read = 1; m1_address = 2'd2; #1;
    total++; if ({mem_clken, mem_chipselect, m1_waitrequest} !== 3'b001) begin bad++; $display("FAIL hold_ctl got=%b exp=001", {mem_clken, mem_chipselect, m1_waitrequest}); end
    for (int k = 0; k < 3; k++) begin
      total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1111_1111) begin bad++; $display("FAIL hold_rdv[%0d] got=%b/%h exp=1/11111111", k, m0_readdatavalid, m0_readdata); end
      step(); #1;
    end
    hold = 0; m1_read = 0; #1;
    total++; if ({mem_clken, m0_readdatavalid} !== 2'b11) begin bad++; $display("FAIL hold_tail got=%b exp=11", {mem_clken, m0_readdatavalid}); end
    step(); #1;
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL hold_end got=%b exp=0", m0_readdatavalid); end
  endtask

  task automatic test_reset_mid();
    idle(); m1_read = 1; m1_address = 2'd3; #1;
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL rm_issue got=%b exp=0", m1_waitrequest); end
    step(); idle(); reset = 1; #1;
    total++; if (m1_readdatavalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rm_assert got=%b%b exp=01", m1_readdatavalid, busy); end
    step();
    total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rm_held got=%b exp=0", m1_readdatavalid); end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({busy, m1_readdatavalid, mem_address} !== {2'b10, 2'(i)}) begin bad++; $display("FAIL rm_clear[%0d] got=%b exp=%b", i, {busy, m1_readdatavalid, mem_address}, {2'b10, 2'(i)}); end
      step();
    end
    m1_read = 1; m1_address = 2'd3; #1;
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL rm_regrant got=%b exp=0", m1_waitrequest); end
    step(); idle(); #1;
    total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rm_early got=%b exp=0", m1_readdatavalid); end
    step(); #1;
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0) begin bad++; $display("FAIL rm_data got=%b/%h exp=1/00000000", m1_readdatavalid, m1_readdata); end
    step();
  endtask

  task automatic test_write_then_read();
    idle(); m0_write = 1; m0_address = 2'd1; m0_writedata = 32'hCAFE_F00D; #1;
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL wtr_wr got=%b exp=0", m0_waitrequest); end
    step(); idle(); m1_read = 1; m1_address = 2'd1; #1;
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL wtr_rd got=%b exp=0", m1_waitrequest); end
    step(); idle(); step(); #1;
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL wtr_data got=%b/%h exp=1/cafef00d", m1_readdatavalid, m1_readdata); end
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL wtr_other got=%b exp=0", m0_readdatavalid); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_write_then_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flappybird_soc_onchip_mem_arbiter.md
# flappybird_soc_onchip_mem_arbiter

Two-port controller placed in front of the 4-word × 32-bit single-port on-chip RAM in the FlappyBird SoC. It shares the RAM between the Nios Avalon-MM data master (port 0) and the game-logic hardware engine (port 1). It zero-fills the RAM after reset and arbitrates single-word read and write accesses round-robin. It also drives the RAM clock-enable so that a hold request freezes the RAM and the arbiter together.

## Interface
Parameters:
- ADDR_W, 2, RAM word-address width; DEPTH = 2**ADDR_W
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip to RUN

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high
- hold  in  1  freeze request (RAM clock-enable deasserted)
- mN_address  in  ADDR_W  port N word address (N = 0, 1)
- mN_byteenable  in  BE_W  port N write byte lanes
- mN_read / mN_write  in  1  port N request; both high together is illegal
- mN_writedata  in  DATA_W  port N write data
- mN_waitrequest  out  1  port N request not accepted this cycle
- mN_readdata  out  DATA_W  port N registered read data
- mN_readdatavalid  out  1  one-cycle read-data strobe
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect, mem_write  out  1  to RAM; write strobe is chipselect & write
- mem_writedata  out  DATA_W  to RAM write data
- mem_readdata  in  DATA_W  RAM q; unregistered, valid the cycle after the address edge
- mem_clken  out  1  to RAM clken; equals ~hold
- busy  out  1  high in CLEAR or while any read is in flight

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise RUN.
- CLEAR: a clear_cnt counter (ADDR_W bits) drives mem_address. The block writes 0 with byteenable all-ones, one word per cycle. After word DEPTH-1 is written, the FSM moves to RUN. Both ports see waitrequest = their request during CLEAR.
- RUN, grant: a port is eligible if its read or write is high. If one port is eligible, it is granted. If both are eligible, the port that was not granted last is granted. The last-grant flop resets to 1, so port 0 wins the first tie.
- Grant issue: the winner's address, byteenable, writedata and write are muxed onto mem_* combinationally. mem_chipselect = 1, and the winner's waitrequest = 0. The loser's waitrequest = 1.
- mN_waitrequest = (mN_read | mN_write) & ~grantN. It is 0 when no request is made.
- Read pipeline: issue at cycle T. At T+1 the block captures mem_readdata into mN_readdata (owner tag recorded at T). At T+2, mN_readdatavalid = 1 for one cycle. One access is accepted per cycle, and reads can be back-to-back.
- Writes complete at the issue edge. No response is generated.
- hold = 1: mem_clken = 0, no grant is made (all waitrequests follow the requests), and the FSM, clear_cnt, pipeline and readdatavalid are all frozen. A valid strobe held during hold stays asserted until hold drops, then lasts one more cycle. Masters must not count readdatavalid cycles while hold is high.
- Width rules: clear_cnt wraps DEPTH-1 → 0 only on the CLEAR→RUN exit. Addresses are used unmodified.

## Timing
- Reset values: state = CLEAR (or RUN if CLEAR_ON_RESET = 0), clear_cnt = 0, mN_readdata = 0, mN_readdatavalid = 0, pipeline valid = 0, last-grant = 1. mem_* outputs are 0, except in CLEAR where chipselect = write = 1 and byteenable = all-ones once reset drops.
- CLEAR takes exactly DEPTH non-held cycles. The first grant can occur in cycle DEPTH after reset release.
- Read latency: 2 cycles from the accepting edge to readdatavalid.
- Reading an address in cycle T+1 that was written in cycle T returns the new data. The write edge precedes the read edge.
- Reset mid-operation: in-flight reads are discarded, no readdatavalid is produced, and CLEAR restarts.

## Structure
- Shared package flappybird_mem_pkg: ADDR_W/DATA_W/BE_W defaults, state enum {CLEAR, RUN}, port-id constants P0 = 0 / P1 = 1.
- One sub-module: flappybird_rr_arb2, a combinational 2-way round-robin pick plus the last-grant flop. The FSM, counter and read pipeline stay in the top level.

## Test plan
- Reset release with CLEAR_ON_RESET = 1: addresses 0..3 are written with 0 in 4 consecutive cycles, busy = 1 throughout, and both waitrequests track the requests. The first grant comes in cycle 4.
- m0 writes 0xDEADBEEF to address 2 with be = 4'b0011, then reads address 2. m0_readdatavalid pulses 2 cycles after acceptance with readdata 0x0000BEEF.
- Both ports read continuously: grants alternate P0, P1, P0, … and each port gets readdatavalid every other cycle with the correct data.
- hold asserted for 3 cycles while a read is in flight: mem_clken = 0 and there is no new grant. readdata is delivered intact and the strobe ends one cycle after hold drops.
- reset asserted one cycle after an m1 read is accepted: m1_readdatavalid never asserts and CLEAR repeats. A read of the old address afterwards returns 0.
- m0 writes address 1 while m1 reads address 1 in the following cycle: m1 receives the new value 2 cycles later.
